// File: rtl/memoria_dados_param_if.sv
// Request/response bundle for memoria_dados_param: one request per cycle in,
// read data plus valid and error strobes out.
interface memoria_dados_param_if #(
    parameter int LARGURA  = 8,
    parameter int BITS_END = 8
);
    logic                   memWrite;
    logic                   memRead;
    logic [BITS_END-1:0]    endereco;
    logic [LARGURA-1:0]     escreveDado;
    logic [LARGURA/8-1:0]   habByte;
    logic [LARGURA-1:0]     leDado;
    logic                   leValido;
    logic                   erro;

    modport master (
        output memWrite, memRead, endereco, escreveDado, habByte,
        input  leDado, leValido, erro
    );

    modport slave (
        input  memWrite, memRead, endereco, escreveDado, habByte,
        output leDado, leValido, erro
    );
endinterface

// File: rtl/memoria_dados_param.sv
// Parametrised single-port data memory, write-first, byte enables, 1- or 2-cycle read.
// Optional address range checking is enabled by defining MEMD_VERIFICA_LIMITE_EN.
module memoria_dados_param #(
    parameter int LARGURA      = 8,
    parameter int BITS_END     = 8,
    parameter int PROFUNDIDADE = 256,
    parameter int LATENCIA     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    memoria_dados_param_if.slave  bus
);
    localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int NB = LARGURA / 8;

    // Words are stored XORed with their power-on pattern, so a zero-initialised
    // array reads back as i+1 in words 0..6 and 0 everywhere else.
    function automatic logic [LARGURA-1:0] init_word(input logic [AW-1:0] a);
        if (32'(a) < 7)
            return LARGURA'(32'(a) + 32'd1);
        else
            return '0;
    endfunction

    logic [LARGURA-1:0] mem [PROFUNDIDADE];

    // Asynchronous assertion, two-flop synchronised release.
    logic [1:0] sync_reg;
    logic       run;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            sync_reg <= '0;
        else
            sync_reg <= {sync_reg[0], 1'b1};
    end

    assign run = sync_reg[1];

    logic [AW-1:0] idx;
    logic          in_range;

    assign idx = AW'(bus.endereco);

`ifdef MEMD_VERIFICA_LIMITE_EN
    assign in_range = (32'(bus.endereco) < PROFUNDIDADE);
`else
    assign in_range = 1'b1;
`endif

    logic               wr_en;
    logic               rd_en;
    logic [LARGURA-1:0] old_word;
    logic [LARGURA-1:0] new_word;
    logic [LARGURA-1:0] rd_word;

    assign wr_en    = run & bus.memWrite & in_range;
    assign rd_en    = run & bus.memRead;
    assign old_word = mem[idx] ^ init_word(idx);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign new_word[8*gi +: 8] = bus.habByte[gi] ? bus.escreveDado[8*gi +: 8]
                                                         : old_word[8*gi +: 8];
        end
    endgenerate

    // Single address port: a simultaneous read always sees the merged write data.
    assign rd_word = !in_range ? '0 : (wr_en ? new_word : old_word);

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[idx] <= new_word ^ init_word(idx);
    end

    logic               v1_reg;
    logic [LARGURA-1:0] d1_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_reg <= 1'b0;
            d1_reg <= '0;
        end else begin
            v1_reg <= rd_en;
            if (rd_en)
                d1_reg <= rd_word;
        end
    end

`ifdef MEMD_VERIFICA_LIMITE_EN
    logic erro_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            erro_reg <= 1'b0;
        else
            erro_reg <= run & (bus.memWrite | bus.memRead) & ~in_range;
    end

    assign bus.erro = erro_reg;
`else
    assign bus.erro = 1'b0;
`endif

    generate
        if (LATENCIA == 2) begin : g_lat2
            logic               v2_reg;
            logic [LARGURA-1:0] d2_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    v2_reg <= 1'b0;
                    d2_reg <= '0;
                end else begin
                    v2_reg <= v1_reg;
                    if (v1_reg)
                        d2_reg <= d1_reg;
                end
            end

            assign bus.leValido = v2_reg;
            assign bus.leDado   = d2_reg;
        end else begin : g_lat1
            assign bus.leValido = v1_reg;
            assign bus.leDado   = d1_reg;
        end
    endgenerate
endmodule

// File: tb/tb_memoria_dados_param.sv
// Bench for memoria_dados_param: an 8-bit/256/latency-1 instance and a
// 16-bit/200/latency-2 instance, directed scenarios then random traffic vs a model.
module tb_memoria_dados_param;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    memoria_dados_param_if #(.LARGURA(8),  .BITS_END(8)) bus_a ();
    memoria_dados_param_if #(.LARGURA(16), .BITS_END(8)) bus_b ();

    memoria_dados_param #(.LARGURA(8), .BITS_END(8), .PROFUNDIDADE(256), .LATENCIA(1))
        dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    memoria_dados_param #(.LARGURA(16), .BITS_END(8), .PROFUNDIDADE(200), .LATENCIA(2))
        dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_a [256];
    logic [15:0] mem_b [200];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic w, input logic r, input logic [7:0] ad,
                           input logic [7:0] dat, input logic be);
        bus_a.memWrite = w; bus_a.memRead = r; bus_a.endereco = ad;
        bus_a.escreveDado = dat; bus_a.habByte = be;
    endtask

    task automatic drive_b(input logic w, input logic r, input logic [7:0] ad,
                           input logic [15:0] dat, input logic [1:0] be);
        bus_b.memWrite = w; bus_b.memRead = r; bus_b.endereco = ad;
        bus_b.escreveDado = dat; bus_b.habByte = be;
    endtask

    task automatic idle_all();
        drive_a(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        drive_b(1'b0, 1'b0, 8'd0, 16'd0, 2'b00);
    endtask

    task automatic release_reset();
        reset = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        idle_all();
        for (int i = 0; i < 256; i++) mem_a[i] = (i < 7) ? 8'(i + 1) : 8'd0;
        for (int i = 0; i < 200; i++) mem_b[i] = (i < 7) ? 16'(i + 1) : 16'd0;
        #2 reset = 1'b0;
        #1;
        checks += 4;
        if (bus_a.leValido !== 1'b0 || bus_a.leDado !== 8'd0) begin
            errors++; $display("FAIL reset_a got v=%0b d=%0h want v=0 d=0", bus_a.leValido, bus_a.leDado);
        end
        if (bus_b.leValido !== 1'b0 || bus_b.leDado !== 16'd0) begin
            errors++; $display("FAIL reset_b got v=%0b d=%0h want v=0 d=0", bus_b.leValido, bus_b.leDado);
        end
        if (bus_a.erro !== 1'b0) begin
            errors++; $display("FAIL reset_erro_a got %0b want 0", bus_a.erro);
        end
        if (bus_b.erro !== 1'b0) begin
            errors++; $display("FAIL reset_erro_b got %0b want 0", bus_b.erro);
        end
        tick();
        release_reset();
    endtask

    task automatic test_initial();
        for (int i = 0; i < 7; i++) begin
            drive_a(1'b0, 1'b1, 8'(i), 8'd0, 1'b0);
            tick();
            checks++;
            if (bus_a.leValido !== 1'b1 || bus_a.leDado !== 8'(i + 1)) begin
                errors++;
                $display("FAIL init_read addr=%0d got v=%0b d=%0h want v=1 d=%0h", i, bus_a.leValido, bus_a.leDado, i + 1);
            end
        end
        idle_all();
        tick();
        checks++;
        if (bus_a.leValido !== 1'b0 || bus_a.leDado !== 8'd7) begin
            errors++; $display("FAIL init_hold got v=%0b d=%0h want v=0 d=7", bus_a.leValido, bus_a.leDado);
        end
    endtask

    task automatic test_byte_enable();
        drive_b(1'b1, 1'b0, 8'd5, 16'hABCD, 2'b01);
        tick();
        mem_b[5] = {mem_b[5][15:8], 8'hCD};
        drive_b(1'b0, 1'b1, 8'd5, 16'd0, 2'b00);
        tick();
        checks++;
        if (bus_b.leValido !== 1'b0) begin
            errors++; $display("FAIL be_latency got v=%0b want 0", bus_b.leValido);
        end
        idle_all();
        tick();
        checks++;
        if (bus_b.leValido !== 1'b1 || bus_b.leDado !== 16'h00CD) begin
            errors++; $display("FAIL be_lane0 got v=%0b d=%0h want v=1 d=00cd", bus_b.leValido, bus_b.leDado);
        end
        drive_a(1'b1, 1'b0, 8'd3, 8'hEE, 1'b0);
        tick();
        drive_a(1'b0, 1'b1, 8'd3, 8'd0, 1'b0);
        tick();
        checks++;
        if (bus_a.leValido !== 1'b1 || bus_a.leDado !== 8'd4) begin
            errors++; $display("FAIL be_none got v=%0b d=%0h want v=1 d=4", bus_a.leValido, bus_a.leDado);
        end
        idle_all();
    endtask

    task automatic test_write_first();
        drive_a(1'b1, 1'b1, 8'd9, 8'h5A, 1'b1);
        tick();
        mem_a[9] = 8'h5A;
        checks++;
        if (bus_a.leValido !== 1'b1 || bus_a.leDado !== 8'h5A) begin
            errors++; $display("FAIL wf_a got v=%0b d=%0h want v=1 d=5a", bus_a.leValido, bus_a.leDado);
        end
        idle_all();
        drive_b(1'b1, 1'b1, 8'd9, 16'h1234, 2'b10);
        tick();
        mem_b[9] = 16'h1200;
        idle_all();
        tick();
        checks++;
        if (bus_b.leValido !== 1'b1 || bus_b.leDado !== 16'h1200) begin
            errors++; $display("FAIL wf_b_merge got v=%0b d=%0h want v=1 d=1200", bus_b.leValido, bus_b.leDado);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] want [3];
        want[0] = 16'd2; want[1] = 16'd3; want[2] = 16'd4;
        drive_b(1'b0, 1'b1, 8'd1, 16'd0, 2'b00);
        tick();
        checks++;
        if (bus_b.leValido !== 1'b0) begin
            errors++; $display("FAIL b2b_early got v=%0b want 0", bus_b.leValido);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive_b(1'b0, 1'b1, 8'(i + 2), 16'd0, 2'b00);
            else idle_all();
            tick();
            checks++;
            if (bus_b.leValido !== 1'b1 || bus_b.leDado !== want[i]) begin
                errors++;
                $display("FAIL b2b_%0d got v=%0b d=%0h want v=1 d=%0h", i, bus_b.leValido, bus_b.leDado, want[i]);
            end
        end
        tick();
        checks++;
        if (bus_b.leValido !== 1'b0 || bus_b.leDado !== 16'd4) begin
            errors++; $display("FAIL b2b_hold got v=%0b d=%0h want v=0 d=4", bus_b.leValido, bus_b.leDado);
        end
    endtask

    task automatic test_reset_mid_read();
        drive_b(1'b0, 1'b1, 8'd0, 16'd0, 2'b00);
        tick();
        idle_all();
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus_b.leValido !== 1'b0 || bus_b.leDado !== 16'd0) begin
            errors++; $display("FAIL midrd_clear got v=%0b d=%0h want v=0 d=0", bus_b.leValido, bus_b.leDado);
        end
        tick();
        checks++;
        if (bus_b.leValido !== 1'b0) begin
            errors++; $display("FAIL midrd_drop got v=%0b want 0", bus_b.leValido);
        end
        release_reset();
        // Write and read presented at the same edge that reset is asserted.
        drive_a(1'b1, 1'b1, 8'd20, 8'h77, 1'b1);
        #1 reset = 1'b0;
        tick();
        checks++;
        if (bus_a.leValido !== 1'b0 || bus_a.leDado !== 8'd0) begin
            errors++; $display("FAIL rst_edge_rd got v=%0b d=%0h want v=0 d=0", bus_a.leValido, bus_a.leDado);
        end
        idle_all();
        release_reset();
        drive_a(1'b0, 1'b1, 8'd20, 8'd0, 1'b0);
        drive_b(1'b0, 1'b1, 8'd0, 16'd0, 2'b00);
        tick();
        checks++;
        if (bus_a.leValido !== 1'b1 || bus_a.leDado !== mem_a[20]) begin
            errors++; $display("FAIL rst_edge_wr got v=%0b d=%0h want v=1 d=%0h", bus_a.leValido, bus_a.leDado, mem_a[20]);
        end
        idle_all();
        tick();
        checks++;
        if (bus_b.leValido !== 1'b1 || bus_b.leDado !== 16'd1) begin
            errors++; $display("FAIL midrd_word0 got v=%0b d=%0h want v=1 d=1", bus_b.leValido, bus_b.leDado);
        end
    endtask

`ifdef MEMD_VERIFICA_LIMITE_EN
    task automatic test_range();
        drive_b(1'b1, 1'b0, 8'd10, 16'h3C3C, 2'b11);
        tick();
        mem_b[10] = 16'h3C3C;
        drive_b(1'b1, 1'b0, 8'd210, 16'h00FF, 2'b11);
        tick();
        checks++;
        if (bus_b.erro !== 1'b1) begin
            errors++; $display("FAIL range_wr_erro got %0b want 1", bus_b.erro);
        end
        idle_all();
        tick();
        checks++;
        if (bus_b.erro !== 1'b0) begin
            errors++; $display("FAIL range_erro_width got %0b want 0", bus_b.erro);
        end
        drive_b(1'b0, 1'b1, 8'd210, 16'd0, 2'b00);
        tick();
        checks++;
        if (bus_b.erro !== 1'b1) begin
            errors++; $display("FAIL range_rd_erro got %0b want 1", bus_b.erro);
        end
        drive_b(1'b0, 1'b1, 8'd10, 16'd0, 2'b00);
        tick();
        checks++;
        if (bus_b.leValido !== 1'b1 || bus_b.leDado !== 16'd0 || bus_b.erro !== 1'b0) begin
            errors++;
            $display("FAIL range_rd_data got v=%0b d=%0h e=%0b want v=1 d=0 e=0", bus_b.leValido, bus_b.leDado, bus_b.erro);
        end
        idle_all();
        tick();
        checks++;
        if (bus_b.leValido !== 1'b1 || bus_b.leDado !== mem_b[10]) begin
            errors++; $display("FAIL range_word10 got v=%0b d=%0h want v=1 d=%0h", bus_b.leValido, bus_b.leDado, mem_b[10]);
        end
    endtask
`endif

    task automatic test_random();
        logic        wa, ra, bea, wb, rb, inr, pend_v, exp_vb, exp_eb;
        logic [7:0]  ada, da, olda, nwa, last_a, adb;
        logic [1:0]  beb;
        logic [15:0] db, oldb, nwb, resb, last_b, pend_d;
        drive_a(1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
        drive_b(1'b0, 1'b1, 8'd0, 16'd0, 2'b00);
        tick();
        idle_all();
        tick();
        last_a = mem_a[0];
        last_b = mem_b[0];
        pend_v = 1'b0;
        pend_d = 16'd0;
        for (int c = 0; c < 400; c++) begin
            wa = 1'($urandom_range(0, 1)); ra = 1'($urandom_range(0, 1));
            bea = 1'($urandom_range(0, 1)); ada = 8'($urandom_range(0, 255));
            da = 8'($urandom);
            wb = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
            beb = 2'($urandom_range(0, 3)); db = 16'($urandom);
`ifdef MEMD_VERIFICA_LIMITE_EN
            adb = 8'($urandom_range(0, 219));
`else
            adb = 8'($urandom_range(0, 199));
`endif
            drive_a(wa, ra, ada, da, bea);
            drive_b(wb, rb, adb, db, beb);
            tick();
            olda = mem_a[ada];
            nwa = bea ? da : olda;
            if (wa) mem_a[ada] = nwa;
            if (ra) last_a = wa ? nwa : olda;
            inr = (adb < 8'd200);
            oldb = inr ? mem_b[adb] : 16'd0;
            nwb = {beb[1] ? db[15:8] : oldb[15:8], beb[0] ? db[7:0] : oldb[7:0]};
            if (wb && inr) mem_b[adb] = nwb;
            resb = !inr ? 16'd0 : (wb ? nwb : oldb);
            exp_vb = pend_v;
            if (pend_v) last_b = pend_d;
            pend_v = rb;
            pend_d = resb;
`ifdef MEMD_VERIFICA_LIMITE_EN
            exp_eb = (wb | rb) & ~inr;
`else
            exp_eb = 1'b0;
`endif
            checks += 4;
            if (bus_a.leValido !== ra || bus_a.leDado !== last_a) begin
                errors++;
                $display("FAIL rand_a cyc=%0d got v=%0b d=%0h want v=%0b d=%0h", c, bus_a.leValido, bus_a.leDado, ra, last_a);
            end
            if (bus_a.erro !== 1'b0) begin
                errors++; $display("FAIL rand_erro_a cyc=%0d got %0b want 0", c, bus_a.erro);
            end
            if (bus_b.leValido !== exp_vb || bus_b.leDado !== last_b) begin
                errors++;
                $display("FAIL rand_b cyc=%0d got v=%0b d=%0h want v=%0b d=%0h", c, bus_b.leValido, bus_b.leDado, exp_vb, last_b);
            end
            if (bus_b.erro !== exp_eb) begin
                errors++; $display("FAIL rand_erro_b cyc=%0d got %0b want %0b", c, bus_b.erro, exp_eb);
            end
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_initial();
        test_byte_enable();
        test_write_first();
        test_back_to_back();
        test_reset_mid_read();
`ifdef MEMD_VERIFICA_LIMITE_EN
        test_range();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
